// File: rtl/alu_seq.sv
// Handshaked execute ALU: single-cycle ops valid 1 cycle after accept, iterative MUL/DIV after XLEN+1.
// One op in flight; in_ready only in IDLE, result/zero held in DONE until out_ready.
module alu_seq #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [SHW-1:0]  cnt_q, cnt_d;

    logic [XLEN-1:0] single_res;
    logic [SHW-1:0]  shamt;
    logic            is_iter_in;
    logic            is_mul_in;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi, mul_lo;
    logic [XLEN:0]   div_sh, div_tr;
    logic            div_ge;
    logic [XLEN-1:0] div_hi, div_lo;
    logic [XLEN-1:0] final_res;

    assign shamt      = b[SHW-1:0];
    assign is_iter_in = MUL_EN && (alu_ctrl >= 4'hA) && (alu_ctrl <= 4'hD);
    assign is_mul_in  = (alu_ctrl[3:1] == 3'b101);

    always_comb begin
        single_res = '0;
        case (alu_ctrl)
            4'h0:    single_res = a + b;
            4'h1:    single_res = a - b;
            4'h2:    single_res = a & b;
            4'h3:    single_res = a | b;
            4'h4:    single_res = a ^ b;
            4'h5:    single_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'h6:    single_res = {{(XLEN-1){1'b0}}, a < b};
            4'h7:    single_res = a << shamt;
            4'h8:    single_res = a >> shamt;
            4'h9:    single_res = $unsigned($signed(a) >>> shamt);
            default: single_res = '0;
        endcase
    end

    // Multiply: {hi,lo} is the partial product, lo initially holds the multiplier.
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

    // Restoring divide: hi is the remainder, lo shifts dividend out and quotient in.
    // A zero divisor naturally yields all-ones quotient and remainder = dividend.
    assign div_sh = {hi_q, lo_q[XLEN-1]};
    assign div_tr = div_sh - {1'b0, opnd_q};
    assign div_ge = ~div_tr[XLEN];
    assign div_hi = div_ge ? div_tr[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_lo = {lo_q[XLEN-2:0], div_ge};

    always_comb begin
        case (ctrl_q)
            4'hA:    final_res = mul_lo;
            4'hB:    final_res = mul_hi;
            4'hC:    final_res = div_lo;
            default: final_res = div_hi;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ctrl_d = alu_ctrl;
                    if (is_iter_in) begin
                        opnd_d  = is_mul_in ? a : b;
                        hi_d    = '0;
                        lo_d    = is_mul_in ? b : a;
                        cnt_d   = SHW'(XLEN-1);
                        state_d = BUSY;
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                hi_d  = ctrl_q[2] ? div_hi : mul_hi;
                lo_d  = ctrl_q[2] ? div_lo : mul_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_d = final_res;
                    zero_d   = (final_res == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (XLEN=32): directed cases plus randomized ops against an arithmetic model.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    alu_seq #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'b0, x} * {32'b0, y};
        case (op)
            4'h0: return x + y;
            4'h1: return x - y;
            4'h2: return x & y;
            4'h3: return x | y;
            4'h4: return x ^ y;
            4'h5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'h6: return (x < y) ? 32'd1 : 32'd0;
            4'h7: return x << y[4:0];
            4'h8: return x >> y[4:0];
            4'h9: return $unsigned($signed(x) >>> y[4:0]);
            4'hA: return p[31:0];
            4'hB: return p[63:32];
            4'hC: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'hD: return (y == 0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    // Every cycle a result is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("result", result, exp_q[0]);
                chk("zero", zero, (exp_q[0] == 0));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input int hold, output logic [31:0] res, output int lat);
        int w;
        int exp_lat;
        exp_lat = (op >= 4'hA && op <= 4'hD) ? 33 : 1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("timeout_in_ready", 0, 1);
        in_valid  = 1'b1;
        alu_ctrl  = op;
        a         = x;
        b         = y;
        out_ready = (hold == 0);
        @(posedge clk);
        exp_q.push_back(model(op, x, y));
        #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        a        = $urandom;
        b        = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && lat > 1) chk("in_ready_low_while_busy", in_ready, 0);
            if (lat == 5) begin
                a = $urandom;
                b = $urandom;
            end
        end while (!out_valid && lat < 100);
        if (!out_valid) chk("timeout_out_valid", 0, 1);
        res = result;
        chk("latency", lat, exp_lat);
        chk("in_ready_low_in_done", in_ready, 0);
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            alu_ctrl  = 4'h0;
            a         = $urandom;
            b         = $urandom;
            repeat (hold) begin
                @(negedge clk);
                chk("out_valid_held", out_valid, 1);
                chk("result_held", result, res);
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_retire_ovld", out_valid, 0);
        chk("idle_after_retire_irdy", in_ready, 1);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            3:       return 32'h8000_0000 | 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        int          l;
        int          w;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_zero", zero, 1);

        // Literal pins on the model itself.
        chk("model_sra", model(4'h9, 32'h8000_0000, 32'h24), 32'hF800_0000);
        chk("model_mulhu", model(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("model_divu0", model(4'hC, 32'd7, 32'd0), 32'hFFFF_FFFF);
        chk("model_remu", model(4'hD, 32'd100, 32'd7), 32'd2);

        do_op(4'h0, 32'hFFFF_FFFF, 32'd1, 0, r, l);         chk("add_wrap", r, 32'd0);
        do_op(4'h9, 32'h8000_0000, 32'h24, 0, r, l);        chk("sra", r, 32'hF800_0000);
        do_op(4'h5, 32'hFFFF_FFFF, 32'd0, 0, r, l);         chk("slt", r, 32'd1);
        do_op(4'h6, 32'hFFFF_FFFF, 32'd0, 0, r, l);         chk("sltu", r, 32'd0);
        do_op(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, l); chk("mulhu", r, 32'hFFFF_FFFE);
        do_op(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, l); chk("mul", r, 32'd1);
        do_op(4'hC, 32'd7, 32'd0, 0, r, l);                 chk("divu_by0", r, 32'hFFFF_FFFF);
        do_op(4'hD, 32'd7, 32'd0, 0, r, l);                 chk("remu_by0", r, 32'd7);
        do_op(4'hC, 32'd100, 32'd7, 0, r, l);               chk("divu", r, 32'd14);
        do_op(4'hD, 32'd100, 32'd7, 0, r, l);               chk("remu", r, 32'd2);
        do_op(4'h0, 32'd3, 32'd4, 5, r, l);                 chk("add_backpressure", r, 32'd7);
        do_op(4'hE, 32'd5, 32'd6, 1, r, l);                 chk("undef_op", r, 32'd0);

        // Reset in the middle of a divide aborts it.
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1; alu_ctrl = 4'hC; a = 32'd100; b = 32'd7; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_in_ready", in_ready, 1);
        out_ready = 1'b0;
        do_op(4'h0, 32'd1, 32'd1, 0, r, l);
        chk("add_after_abort", r, 32'd2);
        chk("add_after_abort_lat", l, 1);

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] x, y;
            op = 4'($urandom_range(0, 15));
            x  = rand_opnd();
            y  = rand_opnd();
            do_op(op, x, y, $urandom_range(0, 2), r, l);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
